mult_8x8_seq: RTL and testbench
===============================

# mult_8x8_seq

Time-multiplexed 8x8 unsigned approximate multiplier controller. It accepts one operand pair over a valid/ready handshake. It sequences the four 4x4 quadrant sub-products (LL, LH, HL, HH) through a single shared configurable 4x4 approximate core, one quadrant per cycle, and accumulates the shifted sub-products into a 16-bit result. It is the area-reduced alternative to the fully parallel four-core 8x8 multiplier; the per-quadrant approximation level is runtime-configurable.

## Interface
- `CFG_RESET`, default 8'h00: per-quadrant mode loaded into the config register at reset (all exact).
- `clk` in 1: clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: operand pair valid.
- `in_ready` out 1: controller can accept an operand pair.
- `a` in 8: multiplicand, unsigned.
- `b` in 8: multiplier, unsigned.
- `cfg_we` in 1: write `cfg_mode` into the config register.
- `cfg_mode` in 8: 2-bit mode per quadrant: [1:0] LL (a[3:0]·b[3:0]), [3:2] LH (a[3:0]·b[7:4]), [5:4] HL (a[7:4]·b[3:0]), [7:6] HH (a[7:4]·b[7:4]).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts result.
- `r` out 16: accumulated product.
- `busy` out 1: high in any state other than IDLE.

## Operation
- FSM states: IDLE, Q0, Q1, Q2, Q3, DONE.
  - IDLE → Q0 on accept.
  - Q0 → Q1 → Q2 → Q3 unconditionally.
  - Q3 → DONE.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → Q0 on `out_ready` together with an accept.
- Accept occurs when `in_valid & in_ready`.
- `in_ready` = (state==IDLE) | (state==DONE & `out_ready`).
- On accept, the controller latches `a`, `b`, a snapshot of the config register, and clears the accumulator to 0.
- Quadrant order is fixed:
  - Q0: LL, added with shift 0.
  - Q1: LH, added with shift 4.
  - Q2: HL, added with shift 4.
  - Q3: HH, added with shift 8.
- 4x4 core, mode m (0..3): the exact 8-bit product with its m LSBs forced to 0. Mode 0 is exact.
- Accumulator is 16 bits, unsigned. It cannot overflow: the maximum is 255·255 = 0xFE01, and approximation only clears bits.
- `r` is driven from the accumulator and is held stable while in DONE.
- Config register:
  - Written on any cycle when `cfg_we` is high, in any state.
  - A write affects only transactions accepted on a later edge.
  - If `cfg_we` and an accept occur on the same edge, the snapshot takes the old value.
- `in_valid` deasserting while not accepted has no effect. Inputs are sampled only on the accept edge.

## Timing
- Reset values: state IDLE; `out_valid`=0, `r`=0, `busy`=0, `in_ready`=1; config register = `CFG_RESET`.
- Reset mid-transaction aborts it immediately; no `out_valid` is produced.
- Latency: accept on edge N; `out_valid` rises after edge N+4. The Q0..Q3 accumulations occur on edges N+1..N+4.
- Throughput: one result per 5 cycles with `out_ready` held high (back-to-back accept in DONE).
- Backpressure: `out_valid` and `r` are held indefinitely while `out_ready`=0.
- `out_ready` asserted outside DONE is ignored.

## Structure
- Shared package holds:
  - state enum;
  - quadrant index constants;
  - mode field width (2);
  - per-quadrant shift constants (0, 4, 4, 8).
- Sub-module `mult_4x4_cfg`: combinational 4x4 core with a 2-bit mode input and 8-bit output.
- Operand-nibble and mode-field selection muxes, keyed by state, stay in the top level.

## Test plan
- Reset, all-exact config: a=0xFF, b=0xFF → `out_valid` 4 cycles after accept, r=0xFE01.
- cfg_mode=8'h03 (LL mode 3): a=0x0F, b=0x0F → LL=0xE1 becomes 0xE0, r=0x00E0. With a=0x12, b=0x34 in exact mode → r=0x03A8.
- Backpressure: hold `out_ready`=0 for 10 cycles in DONE → `r` stable, `in_ready`=0. Release with `in_valid` high → same-edge accept of the next pair, and the correct next result follows.
- Config race: `cfg_we` with 8'hFF on the accept edge of a=0x0F, b=0x0F → old config used (r=0x00E1 under exact). The next transaction uses all-mode-3: r=0x00E0.
- Reset asserted in Q2 → outputs return to reset values at once. A subsequent a=3, b=5 → r=15.
- Random 1000 pairs, all-exact config, random `out_ready` stalls → r=a·b each time, no lost or duplicated results.

Source files
------------

// File: rtl/mult_8x8_seq_pkg.sv
// ---------------------------------------------------------------------------
// mult_8x8_seq_pkg
// Shared definitions for the time-multiplexed 8x8 approximate multiplier:
//   - controller state encoding
//   - quadrant indices (position of each 2-bit mode field in the config byte)
//   - mode field width
//   - left-shift applied to each quadrant sub-product before accumulation
// ---------------------------------------------------------------------------
package mult_8x8_seq_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_Q0   = 3'd1,
        ST_Q1   = 3'd2,
        ST_Q2   = 3'd3,
        ST_Q3   = 3'd4,
        ST_DONE = 3'd5
    } state_t;

    // Quadrant index == field index inside the 8-bit config word.
    localparam int unsigned QUAD_LL = 0;  // a[3:0] * b[3:0]
    localparam int unsigned QUAD_LH = 1;  // a[3:0] * b[7:4]
    localparam int unsigned QUAD_HL = 2;  // a[7:4] * b[3:0]
    localparam int unsigned QUAD_HH = 3;  // a[7:4] * b[7:4]

    localparam int unsigned MODE_W = 2;

    localparam logic [3:0] SHIFT_LL = 4'd0;
    localparam logic [3:0] SHIFT_LH = 4'd4;
    localparam logic [3:0] SHIFT_HL = 4'd4;
    localparam logic [3:0] SHIFT_HH = 4'd8;

endpackage

// File: rtl/mult_8x8_seq_core.sv
// ---------------------------------------------------------------------------
// mult_4x4_cfg
// Combinational configurable 4x4 unsigned approximate multiplier.
// Mode m (0..3) returns the exact 8-bit product with its m LSBs cleared;
// mode 0 is exact.
// Ports:
//   i_a    [3:0]  multiplicand nibble
//   i_b    [3:0]  multiplier nibble
//   i_mode [1:0]  approximation level
//   o_p    [7:0]  (approximate) product
// ---------------------------------------------------------------------------
module mult_4x4_cfg
    import mult_8x8_seq_pkg::*;
(
    input  logic [3:0]        i_a,
    input  logic [3:0]        i_b,
    input  logic [MODE_W-1:0] i_mode,
    output logic [7:0]        o_p
);

    logic [7:0] w_exact;
    logic [7:0] w_mask;

    assign w_exact = 8'(i_a) * 8'(i_b);

    always_comb begin
        w_mask = 8'hFF;
        case (i_mode)
            2'd0:    w_mask = 8'hFF;
            2'd1:    w_mask = 8'hFE;
            2'd2:    w_mask = 8'hFC;
            default: w_mask = 8'hF8;
        endcase
    end

    assign o_p = w_exact & w_mask;

endmodule

// File: rtl/mult_8x8_seq.sv
// ---------------------------------------------------------------------------
// mult_8x8_seq
// Time-multiplexed 8x8 unsigned approximate multiplier. One operand pair is
// accepted, then the four 4x4 quadrant sub-products (LL, LH, HL, HH) are run
// through a single shared mult_4x4_cfg core, one per cycle, and accumulated
// with their shifts into a 16-bit result.
// Ports:
//   clk, rst_n              clock (rising edge), async active-low reset
//   in_valid / in_ready     operand handshake, a[7:0] and b[7:0]
//   cfg_we, cfg_mode[7:0]   config write: 2-bit mode per quadrant
//                           [1:0] LL, [3:2] LH, [5:4] HL, [7:6] HH
//   out_valid / out_ready   result handshake, r[15:0]
//   busy                    high whenever the controller is not idle
// Parameter:
//   CFG_RESET               config register value after reset
// ---------------------------------------------------------------------------
module mult_8x8_seq
    import mult_8x8_seq_pkg::*;
#(
    parameter logic [7:0] CFG_RESET = 8'h00
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  a,
    input  logic [7:0]  b,
    input  logic        cfg_we,
    input  logic [7:0]  cfg_mode,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] r,
    output logic        busy
);

    // Handshakes: a transfer happens on a rising edge where valid and ready
    // are both high. in_ready does not depend on in_valid; out_valid does not
    // depend on out_ready. out_valid/r hold until out_ready is seen in DONE,
    // and a new pair may be accepted on that same edge.

    state_t      r_state;
    state_t      w_next_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [7:0]  r_cfg;
    logic [7:0]  r_snap;
    logic [15:0] r_acc;

    logic              w_accept;
    logic [3:0]        w_nib_a;
    logic [3:0]        w_nib_b;
    logic [MODE_W-1:0] w_mode;
    logic [3:0]        w_shift;
    logic [7:0]        w_prod;
    logic [15:0]       w_term;

    assign in_ready  = (r_state == ST_IDLE) || ((r_state == ST_DONE) && out_ready);
    assign w_accept  = in_valid && in_ready;
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign r         = r_acc;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next_state = ST_Q0;
            ST_Q0:   w_next_state = ST_Q1;
            ST_Q1:   w_next_state = ST_Q2;
            ST_Q2:   w_next_state = ST_Q3;
            ST_Q3:   w_next_state = ST_DONE;
            ST_DONE: begin
                if (w_accept)       w_next_state = ST_Q0;
                else if (out_ready) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // ---------------- Quadrant selection ----------------
    always_comb begin
        w_nib_a = r_a[3:0];
        w_nib_b = r_b[3:0];
        w_mode  = r_snap[QUAD_LL*MODE_W +: MODE_W];
        w_shift = SHIFT_LL;
        case (r_state)
            ST_Q1: begin
                w_nib_a = r_a[3:0];
                w_nib_b = r_b[7:4];
                w_mode  = r_snap[QUAD_LH*MODE_W +: MODE_W];
                w_shift = SHIFT_LH;
            end
            ST_Q2: begin
                w_nib_a = r_a[7:4];
                w_nib_b = r_b[3:0];
                w_mode  = r_snap[QUAD_HL*MODE_W +: MODE_W];
                w_shift = SHIFT_HL;
            end
            ST_Q3: begin
                w_nib_a = r_a[7:4];
                w_nib_b = r_b[7:4];
                w_mode  = r_snap[QUAD_HH*MODE_W +: MODE_W];
                w_shift = SHIFT_HH;
            end
            default: ;
        endcase
    end

    mult_4x4_cfg u_core (
        .i_a    (w_nib_a),
        .i_b    (w_nib_b),
        .i_mode (w_mode),
        .o_p    (w_prod)
    );

    assign w_term = 16'(w_prod) << w_shift;

    // ---------------- Config register ----------------
    // The snapshot is taken from r_cfg before this edge's write lands, so a
    // same-edge cfg_we only affects later transactions.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cfg <= CFG_RESET;
        end else if (cfg_we) begin
            r_cfg <= cfg_mode;
        end
    end

    // ---------------- Datapath ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= 8'h00;
            r_b    <= 8'h00;
            r_snap <= CFG_RESET;
            r_acc  <= 16'h0000;
        end else if (w_accept) begin
            r_a    <= a;
            r_b    <= b;
            r_snap <= r_cfg;
            r_acc  <= 16'h0000;
        end else begin
            case (r_state)
                // Max total is 0xFE01 and approximation only clears bits,
                // so the 16-bit sum never wraps.
                ST_Q0, ST_Q1, ST_Q2, ST_Q3: r_acc <= r_acc + w_term;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_8x8_seq.sv
// ---------------------------------------------------------------------------
// tb_mult_8x8_seq
// Directed checks of reset, latency, exact and approximate products,
// backpressure, config race and mid-transaction reset, followed by a
// random all-exact run with random out_ready stalls scored through a queue.
// ---------------------------------------------------------------------------
module tb_mult_8x8_seq;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        cfg_we;
    logic [7:0]  cfg_mode;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] r;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int n_rx  = 0;
    logic mon_en = 1'b0;
    logic rnd_stall = 1'b0;
    logic [15:0] exp_q[$];

    mult_8x8_seq #(.CFG_RESET(8'h00)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cfg_we    (cfg_we),
        .cfg_mode  (cfg_mode),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .r         (r),
        .busy      (busy)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- driver tasks ----------------
    // Presents a pair and returns #1 after the accept edge.
    task automatic accept_pair(input logic [7:0] va, input logic [7:0] vb);
        logic ok;
        ok = 1'b0;
        in_valid = 1'b1;
        a = va;
        b = vb;
        for (int k = 0; k < 40; k++) begin
            if (rnd_stall) out_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            if (in_ready) ok = 1'b1;
            @(posedge clk);
            #1;
            if (ok) break;
        end
        in_valid = 1'b0;
        cfg_we   = 1'b0;
        a = $urandom_range(0, 255);
        b = $urandom_range(0, 255);
        check("accept_timeout", 32'(ok), 32'd1);
    endtask

    // Called #1 after the accept edge; expects out_valid after 4 more edges.
    task automatic wait_result(input string tag, input logic [15:0] expv);
        int lat;
        lat = 0;
        while (!out_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 32'(lat), 32'd4);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_r"}, 32'(r), 32'(expv));
    endtask

    task automatic write_cfg(input logic [7:0] m);
        cfg_we = 1'b1;
        cfg_mode = m;
        tick();
        cfg_we = 1'b0;
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (mon_en && rst_n && out_valid && out_ready) begin
            n_rx++;
            if (exp_q.size() == 0) begin
                check("rnd_unexpected_result", 32'(r), 32'hFFFF_FFFF);
            end else begin
                check("rnd_r", 32'(r), 32'(exp_q.pop_front()));
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] ra;
        logic [7:0] rb;

        rst_n = 1'b0;
        in_valid = 1'b0;
        a = 8'h00;
        b = 8'h00;
        cfg_we = 1'b0;
        cfg_mode = 8'h00;
        out_ready = 1'b1;

        tick();
        tick();
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_r", 32'(r), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        rst_n = 1'b1;
        tick();

        // Full-scale exact product
        accept_pair(8'hFF, 8'hFF);
        check("ff_busy", 32'(busy), 32'd1);
        wait_result("ff", 16'hFE01);
        tick();
        check("ff_back_idle", 32'(busy), 32'd0);

        // LL in mode 3: 0xE1 -> 0xE0
        write_cfg(8'h03);
        accept_pair(8'h0F, 8'h0F);
        wait_result("ll_m3", 16'h00E0);
        tick();
        write_cfg(8'h00);
        accept_pair(8'h12, 8'h34);
        wait_result("exact_1234", 16'h03A8);
        tick();

        // Backpressure: hold the result, then release with a pair waiting
        out_ready = 1'b0;
        accept_pair(8'h25, 8'h0B);
        wait_result("bp", 16'h0197);
        for (int k = 0; k < 10; k++) begin
            tick();
            check("bp_hold_r", 32'(r), 32'h0197);
            check("bp_hold_in_ready", 32'(in_ready), 32'd0);
            check("bp_hold_valid", 32'(out_valid), 32'd1);
        end
        out_ready = 1'b1;
        accept_pair(8'h80, 8'h02);
        wait_result("bp_next", 16'h0100);
        tick();
        tick();

        // Config write on the accept edge: old (exact) config applies
        cfg_we = 1'b1;
        cfg_mode = 8'hFF;
        accept_pair(8'h0F, 8'h0F);
        wait_result("race_old", 16'h00E1);
        tick();
        accept_pair(8'h0F, 8'h0F);
        wait_result("race_new", 16'h00E0);
        tick();
        // All quadrants mode 3: 0xE0 + 0xE00 + 0xE00 + 0xE000
        accept_pair(8'hFF, 8'hFF);
        wait_result("all_m3_ff", 16'hFCE0);
        tick();
        write_cfg(8'h00);

        // Reset while in Q2 (two edges after accept)
        accept_pair(8'hFF, 8'hFF);
        tick();
        tick();
        check("q2_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_r", 32'(r), 32'd0);
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) tick();
        check("midrst_no_valid", 32'(out_valid), 32'd0);
        accept_pair(8'd3, 8'd5);
        wait_result("after_rst", 16'd15);
        tick();

        // Random pairs with random out_ready stalls
        mon_en = 1'b1;
        rnd_stall = 1'b1;
        for (int i = 0; i < 1000; i++) begin
            ra = 8'($urandom_range(0, 255));
            rb = 8'($urandom_range(0, 255));
            accept_pair(ra, rb);
            exp_q.push_back(16'(ra) * 16'(rb));
        end
        rnd_stall = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 50; k++) begin
            if (exp_q.size() == 0) break;
            tick();
        end
        tick();
        mon_en = 1'b0;
        check("rnd_queue_drained", 32'(exp_q.size()), 32'd0);
        check("rnd_result_count", 32'(n_rx), 32'd1000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
